// File: rtl/extend.sv
// extend: immediate extension unit for the instruction decoder.
//
// Turns the 12-bit instruction immediate into a 32-bit operand. A memory
// offset is zero-extended from all 12 bits. A data-processing immediate is
// zero-extended from its low 8 bits. The unit also gives the shifter
// carry-out for that immediate. A registered copy of the operand can be
// captured under an enable.
//
// Build option:
//   EXTEND_ROTATE_EN - when defined, a data-processing immediate is rotated
//                      right by 2*instr_imm[11:8] bit positions, in the ARM
//                      rotate-immediate form. When it is undefined, the
//                      rotate field is ignored and imm_carry always equals
//                      carry_in.
//
// Parameters:
//   IMM_W  - immediate field width (only 12 is supported)
//   DATA_W - extended operand width (only 32 is supported)
//
// Ports:
//   clk         in   clock; all state changes on the rising edge
//   reset       in   synchronous active-high reset of the registered outputs
//   instr_imm   in   raw immediate field [IMM_W-1:0]
//   imm_src     in   1 = 12-bit zero-extend, 0 = 8-bit data-processing imm
//   carry_in    in   current C flag
//   en          in   capture enable for ext_imm_q / ext_imm_vld
//   ext_imm     out  combinational extended immediate [DATA_W-1:0]
//   imm_carry   out  combinational shifter carry-out
//   ext_imm_q   out  registered ext_imm
//   ext_imm_vld out  registered flag: ext_imm_q holds a captured value
module extend #(
   parameter int unsigned IMM_W  = 12,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IMM_W-1:0]  instr_imm,
   input  logic              imm_src,
   input  logic              carry_in,
   input  logic              en,
   output logic [DATA_W-1:0] ext_imm,
   output logic              imm_carry,
   output logic [DATA_W-1:0] ext_imm_q,
   output logic              ext_imm_vld
);

   localparam int unsigned IMM8_W = 8;
   localparam int unsigned ROT_W  = 4;
   localparam int unsigned SHAM_W = ROT_W + 1;

   logic [IMM8_W-1:0] imm8;
   logic [ROT_W-1:0]  rot_field;
   logic [DATA_W-1:0] imm8_zx;
   logic [DATA_W-1:0] imm12_zx;
   logic [DATA_W-1:0] dp_imm;
   logic              dp_carry;

   assign imm8      = instr_imm[IMM8_W-1:0];
   assign rot_field = instr_imm[IMM_W-1:IMM_W-ROT_W];
   assign imm8_zx   = DATA_W'(imm8);
   assign imm12_zx  = DATA_W'(instr_imm);

`ifdef EXTEND_ROTATE_EN
   // Rotate right by twice the 4-bit field. Shifting two copies side by side
   // gives the rotate without a barrel of muxes.
   logic [SHAM_W-1:0] rot_amt;

   assign rot_amt = {rot_field, 1'b0};

   always_comb begin
      dp_imm   = DATA_W'({imm8_zx, imm8_zx} >> rot_amt);
      // A zero rotate leaves C untouched. Otherwise C takes the top result bit.
      dp_carry = (rot_field != '0) ? dp_imm[DATA_W-1] : carry_in;
   end
`else
   // The rotate field has no effect in this build.
   logic unused_rot;

   assign unused_rot = ^rot_field;

   always_comb begin
      dp_imm   = imm8_zx;
      dp_carry = carry_in;
   end
`endif

   // Select the operand and the carry-out between the two immediate forms.
   always_comb begin
      ext_imm   = imm12_zx;
      imm_carry = carry_in;
      if (!imm_src) begin
         ext_imm   = dp_imm;
         imm_carry = dp_carry;
      end
   end

   // Registered capture path.
   logic [DATA_W-1:0] cap_imm_d, cap_imm_q;
   logic              cap_vld_d, cap_vld_q;

   always_comb begin
      cap_imm_d = cap_imm_q;
      cap_vld_d = cap_vld_q;
      if (en) begin
         cap_imm_d = ext_imm;
         cap_vld_d = 1'b1;
      end
   end

   // Reset overrides en, so a capture in the reset cycle is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_imm_q <= '0;
         cap_vld_q <= 1'b0;
      end else begin
         cap_imm_q <= cap_imm_d;
         cap_vld_q <= cap_vld_d;
      end
   end

   assign ext_imm_q   = cap_imm_q;
   assign ext_imm_vld = cap_vld_q;

endmodule

// File: tb/tb_extend.sv
// tb_extend: directed bench for extend with a scoreboard of expected results.
// The expectations follow the EXTEND_ROTATE_EN setting of the build.
module tb_extend;

   logic        clk;
   logic        reset;
   logic [11:0] instr_imm;
   logic        imm_src;
   logic        carry_in;
   logic        en;
   logic [31:0] ext_imm;
   logic        imm_carry;
   logic [31:0] ext_imm_q;
   logic        ext_imm_vld;

   int tests;
   int fails;

   typedef struct {
      string       tag;
      logic [31:0] imm;
      logic        bit1;
   } exp_t;

   exp_t comb_sb[$];
   exp_t reg_sb[$];

   extend #(.IMM_W(12), .DATA_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_imm   (instr_imm),
      .imm_src     (imm_src),
      .carry_in    (carry_in),
      .en          (en),
      .ext_imm     (ext_imm),
      .imm_carry   (imm_carry),
      .ext_imm_q   (ext_imm_q),
      .ext_imm_vld (ext_imm_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. Rotates one bit at a time.
   function automatic logic [31:0] m_imm(input logic [11:0] i, input logic src);
      logic [31:0] v;
      int          n;
      if (src) return {20'b0, i};
      v = {24'b0, i[7:0]};
      n = 2 * int'(i[11:8]);
`ifdef EXTEND_ROTATE_EN
      for (int k = 0; k < n; k++) v = {v[0], v[31:1]};
`else
      n = 0;
`endif
      return v;
   endfunction

   function automatic logic m_carry(input logic [11:0] i, input logic src,
                                    input logic cin);
`ifdef EXTEND_ROTATE_EN
      logic [31:0] v;
      v = m_imm(i, src);
      if (!src && i[11:8] != 4'h0) return v[31];
`endif
      return cin;
   endfunction

   // Drive the combinational inputs and queue the model result.
   task automatic drive_comb(input string tag, input logic [11:0] i,
                             input logic src, input logic cin);
      exp_t e;
      instr_imm = i;
      imm_src   = src;
      carry_in  = cin;
      e.tag  = tag;
      e.imm  = m_imm(i, src);
      e.bit1 = m_carry(i, src, cin);
      comb_sb.push_back(e);
   endtask

   // Queue a fixed expectation (the vectors with known answers).
   task automatic push_comb_fixed(input string tag, input logic [31:0] imm,
                                  input logic c);
      exp_t e;
      void'(comb_sb.pop_back());
      e.tag  = tag;
      e.imm  = imm;
      e.bit1 = c;
      comb_sb.push_back(e);
   endtask

   task automatic check_comb();
      exp_t e;
      #1;
      if (comb_sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL comb_sb_empty observed=0 expected=1");
         return;
      end
      e = comb_sb.pop_front();
      tests++;
      assert (ext_imm === e.imm) else begin
         fails++;
         $error("FAIL %s ext_imm observed=%h expected=%h", e.tag, ext_imm, e.imm);
      end
      tests++;
      assert (imm_carry === e.bit1) else begin
         fails++;
         $error("FAIL %s imm_carry observed=%b expected=%b", e.tag, imm_carry, e.bit1);
      end
   endtask

   task automatic push_reg(input string tag, input logic [31:0] q, input logic v);
      exp_t e;
      e.tag  = tag;
      e.imm  = q;
      e.bit1 = v;
      reg_sb.push_back(e);
   endtask

   // Step one clock edge, then compare the registered outputs.
   task automatic step_check_reg();
      exp_t e;
      @(posedge clk);
      #1;
      if (reg_sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL reg_sb_empty observed=0 expected=1");
         return;
      end
      e = reg_sb.pop_front();
      tests++;
      assert (ext_imm_q === e.imm) else begin
         fails++;
         $error("FAIL %s ext_imm_q observed=%h expected=%h", e.tag, ext_imm_q, e.imm);
      end
      tests++;
      assert (ext_imm_vld === e.bit1) else begin
         fails++;
         $error("FAIL %s ext_imm_vld observed=%b expected=%b", e.tag, ext_imm_vld, e.bit1);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      reset     = 1'b1;
      en        = 1'b0;
      instr_imm = 12'h000;
      imm_src   = 1'b1;
      carry_in  = 1'b0;

      // Reset state.
      #2;
      push_reg("reset", 32'h0, 1'b0);
      step_check_reg();

      // The combinational path is checked while reset is still high.
      drive_comb("zero_src1", 12'h000, 1'b1, 1'b1);
      push_comb_fixed("zero_src1", 32'h0000_0000, 1'b1);
      check_comb();
      reset = 1'b0;

      drive_comb("fff_src1", 12'hfff, 1'b1, 1'b0);
      push_comb_fixed("fff_src1", 32'h0000_0fff, 1'b0);
      check_comb();

      drive_comb("0ff_src0", 12'h0ff, 1'b0, 1'b1);
      push_comb_fixed("0ff_src0", 32'h0000_00ff, 1'b1);
      check_comb();

      drive_comb("4ff_src0", 12'h4ff, 1'b0, 1'b0);
`ifdef EXTEND_ROTATE_EN
      push_comb_fixed("4ff_src0", 32'hff00_0000, 1'b1);
`else
      push_comb_fixed("4ff_src0", 32'h0000_00ff, 1'b0);
`endif
      check_comb();

      drive_comb("f01_rot30", 12'hf01, 1'b0, 1'b1);
`ifdef EXTEND_ROTATE_EN
      push_comb_fixed("f01_rot30", 32'h0000_0004, 1'b0);
`else
      push_comb_fixed("f01_rot30", 32'h0000_0001, 1'b1);
`endif
      check_comb();

      drive_comb("180_rot2", 12'h180, 1'b0, 1'b1);
      check_comb();
      drive_comb("3ab_src1", 12'h3ab, 1'b1, 1'b1);
      check_comb();
      drive_comb("c81_src0", 12'hc81, 1'b0, 1'b0);
      check_comb();

      // With en low after reset, the registered outputs stay cleared.
      push_reg("idle", 32'h0, 1'b0);
      step_check_reg();

      // Capture.
      en = 1'b1;
      drive_comb("cap_123", 12'h123, 1'b1, 1'b0);
      push_reg("capture", 32'h0000_0123, 1'b1);
      step_check_reg();
      void'(comb_sb.pop_front());

      // Hold with a new input.
      en = 1'b0;
      drive_comb("hold_in", 12'h0ff, 1'b0, 1'b0);
      check_comb();
      push_reg("hold", 32'h0000_0123, 1'b1);
      step_check_reg();

      // Reset together with en discards the capture.
      reset = 1'b1;
      en    = 1'b1;
      drive_comb("rst_en_in", 12'hfff, 1'b1, 1'b1);
      check_comb();
      push_reg("reset_en", 32'h0, 1'b0);
      step_check_reg();

      // Capture of a data-processing immediate.
      reset = 1'b0;
      drive_comb("cap_4ff", 12'h4ff, 1'b0, 1'b0);
      push_reg("capture_dp", m_imm(12'h4ff, 1'b0), 1'b1);
      step_check_reg();
      check_comb();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/extend.md
EXTEND -- requirements
Module: extend

Interface
REQ-001 Parameter IMM_W, default 12, instruction immediate field width; only the value 12 is supported.
REQ-002 Parameter DATA_W, default 32, extended output width; only the value 32 is supported.
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port instr_imm, input, 12, raw immediate field of instruction.
REQ-006 Port imm_src, input, 1, 1 = 12-bit zero-extend (memory offset), 0 = 8-bit data-processing immediate.
REQ-007 Port carry_in, input, 1, current C flag used for immediate carry-out.
REQ-008 Port en, input, 1, capture enable for registered outputs.
REQ-009 Port ext_imm, output, 32, combinational extended immediate.
REQ-010 Port imm_carry, output, 1, combinational shifter carry-out of the immediate.
REQ-011 Port ext_imm_q, output, 32, registered copy of ext_imm.
REQ-012 Port ext_imm_vld, output, 1, registered flag indicating ext_imm_q holds a captured value.

Function
REQ-013 ext_imm and imm_carry SHALL be purely combinational from instr_imm, imm_src and carry_in, with zero-cycle latency and no dependence on clk, reset or en.
REQ-014 When imm_src=1, ext_imm SHALL be {20'b0, instr_imm[11:0]}.
REQ-015 When imm_src=0 and EXTEND_ROTATE_EN is defined, ext_imm SHALL be {24'b0, instr_imm[7:0]} rotated right by 2*instr_imm[11:8] bit positions, with rotate amounts 0..30.
REQ-016 When imm_src=0 and EXTEND_ROTATE_EN is undefined, ext_imm SHALL be {24'b0, instr_imm[7:0]}, and instr_imm[11:8] SHALL be ignored.
REQ-017 imm_carry SHALL equal ext_imm[31] when imm_src=0, rotation is enabled, and instr_imm[11:8]!=0; in all other cases it SHALL equal carry_in.
REQ-018 On a rising clk edge with reset=0 and en=1, ext_imm_q SHALL load the current ext_imm and ext_imm_vld SHALL become 1.
REQ-019 On a rising clk edge with reset=0 and en=0, ext_imm_q and ext_imm_vld SHALL hold their values.
REQ-020 No X or Z SHALL appear on any output when all inputs are known.

Reset
REQ-021 A rising clk edge with reset=1 SHALL set ext_imm_q=32'h0 and ext_imm_vld=0, overriding en.
REQ-022 Reset SHALL NOT affect ext_imm or imm_carry.
REQ-023 Asserting reset in the same cycle as en=1 SHALL discard the capture.

Configuration
REQ-024 The macro EXTEND_ROTATE_EN SHALL compile in the ARM rotate-immediate datapath of REQ-015 and REQ-017; without the macro, the behaviour of REQ-016 applies and imm_carry always equals carry_in.

Verification
REQ-025 instr_imm=12'h000, imm_src=1 -> ext_imm=32'h00000000, imm_carry=carry_in.
REQ-026 instr_imm=12'hfff, imm_src=1 -> ext_imm=32'h00000fff.
REQ-027 instr_imm=12'h0ff, imm_src=0 -> ext_imm=32'h000000ff in both macro configurations.
REQ-028 instr_imm=12'h4ff, imm_src=0, carry_in=0 -> ext_imm=32'hff000000 and imm_carry=1 with EXTEND_ROTATE_EN defined; ext_imm=32'h000000ff and imm_carry=0 without the macro.
REQ-029 Registered-output sequence:
- reset=1 for one edge -> ext_imm_q=0, ext_imm_vld=0.
- en=1 with instr_imm=12'h123, imm_src=1 -> next edge ext_imm_q=32'h00000123, ext_imm_vld=1.
- en=0 with a new input -> ext_imm_q holds 32'h00000123.
- reset=1 together with en=1 -> ext_imm_q=0, ext_imm_vld=0.
